// File: rtl/control_fsm_if.sv
// Control bundle between the multi-cycle control unit and the shared RV32I datapath.
// Instruction fields and the zero flag flow in; enables, selects and debug state flow out.
interface control_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic       reg_write;
    logic [1:0] imm_src;
    logic [3:0] state;
    logic       illegal_op;

    modport master (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_control, reg_write, imm_src, state, illegal_op
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
               alu_control, reg_write, imm_src, state, illegal_op
    );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle RV32I main control: Moore sequencer plus ALU and immediate-format decoders.
// Sole driver of datapath write enables; all of them are held low while reset is high.
module control_fsm (
    input  logic          clk,
    input  logic          reset,
    control_fsm_if.master bus
);
    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StExecR    = 4'd6;
    localparam logic [3:0] StAluWb    = 4'd7;
    localparam logic [3:0] StExecI    = 4'd8;
    localparam logic [3:0] StJal      = 4'd9;
    localparam logic [3:0] StBeq      = 4'd10;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpBeq   = 7'b1100011;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    logic [3:0] r_state;
    logic [3:0] w_state_dec;
    logic [3:0] w_state_next;
    logic [1:0] w_alu_op;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_illegal;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Under reset the outputs decode as FETCH whatever state the register holds.
    assign w_state_dec = reset ? StFetch : r_state;

    always_comb begin
        w_state_next   = StFetch;
        w_alu_op       = AluOpAdd;
        w_pc_update    = 1'b0;
        w_branch       = 1'b0;
        w_illegal      = 1'b0;
        w_ir_write     = 1'b0;
        w_mem_write    = 1'b0;
        w_reg_write    = 1'b0;
        bus.adr_src    = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        case (w_state_dec)
            StFetch: begin
                w_ir_write     = 1'b1;
                w_pc_update    = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                w_state_next   = StDecode;
            end
            StDecode: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                case (bus.op)
                    OpLoad, OpStore: w_state_next = StMemAdr;
                    OpRtype:         w_state_next = StExecR;
                    OpItype:         w_state_next = StExecI;
                    OpJal:           w_state_next = StJal;
                    OpBeq:           w_state_next = StBeq;
                    default:         w_illegal    = 1'b1;
                endcase
            end
            StMemAdr: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                w_state_next  = bus.op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                bus.adr_src  = 1'b1;
                w_state_next = StMemWb;
            end
            StMemWb: begin
                bus.result_src = 2'b01;
                w_reg_write    = 1'b1;
            end
            StMemWrite: begin
                bus.adr_src = 1'b1;
                w_mem_write = 1'b1;
            end
            StExecR: begin
                bus.alu_src_a = 2'b10;
                w_alu_op      = AluOpFunct;
                w_state_next  = StAluWb;
            end
            StExecI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                w_alu_op      = AluOpFunct;
                w_state_next  = StAluWb;
            end
            StAluWb: w_reg_write = 1'b1;
            StJal: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                w_pc_update   = 1'b1;
                w_state_next  = StAluWb;
            end
            StBeq: begin
                bus.alu_src_a = 2'b10;
                w_alu_op      = AluOpSub;
                w_branch      = 1'b1;
            end
            default: w_state_next = StFetch;
        endcase
    end

    always_comb begin
        bus.alu_control = 3'b000;
        case (w_alu_op)
            AluOpSub: bus.alu_control = 3'b001;
            AluOpFunct: begin
                case (bus.funct3)
                    3'b000:  bus.alu_control = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  bus.alu_control = 3'b101;
                    3'b110:  bus.alu_control = 3'b011;
                    3'b111:  bus.alu_control = 3'b010;
                    default: bus.alu_control = 3'b000;
                endcase
            end
            default: bus.alu_control = 3'b000;
        endcase
    end

    always_comb begin
        case (bus.op)
            OpStore: bus.imm_src = 2'b01;
            OpBeq:   bus.imm_src = 2'b10;
            OpJal:   bus.imm_src = 2'b11;
            default: bus.imm_src = 2'b00;
        endcase
    end

    assign bus.pc_write   = ~reset & (w_pc_update | (w_branch & bus.zero));
    assign bus.ir_write   = ~reset & w_ir_write;
    assign bus.mem_write  = ~reset & w_mem_write;
    assign bus.reg_write  = ~reset & w_reg_write;
    assign bus.illegal_op = ~reset & w_illegal;
    assign bus.state      = r_state;
endmodule

// File: doc/control_fsm.md
# control_fsm

Main control unit of the multi-cycle RV32I core. It decodes the opcode held in the instruction register and sequences the shared datapath one step per clock: PC, memory, register file, ALU and the immediate extender's `imm_src` select. It contains a Moore main state machine, a combinational immediate-format decoder and an ALU decoder. It is the only block in the multi-cycle core that drives datapath write enables.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `op` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = result.
- `mem_write` out 1: data memory write enable.
- `ir_write` out 1: instruction register / old-PC enable.
- `result_src` out 2: 00 = ALUOut, 01 = read data, 10 = ALU result.
- `alu_src_a` out 2: 00 = PC, 01 = old PC, 10 = RD1.
- `alu_src_b` out 2: 00 = RD2, 01 = imm_ext, 10 = constant 4.
- `alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `reg_write` out 1: register file write enable.
- `imm_src` out 2: extender format; 00 I, 01 S, 10 B, 11 J.
- `state` out 4: current state encoding, for debug and the bench.
- `illegal_op` out 1: 1-cycle pulse when an unsupported opcode is seen in DECODE.

## Operation
- State register is 4 bits. Encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4
  - MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10
- Codes 11–15 are unreachable; if entered, next state is FETCH.
- All outputs decode combinationally from `state`, plus `op`, `funct3`, `funct7b5` and `zero`. Every signal not listed for a state is 0.
- `pc_write = pc_update | (branch & zero)`.
- FETCH:
  - Outputs: `adr_src`=0, `ir_write`=1, `alu_src_a`=00, `alu_src_b`=10, add, `result_src`=10, pc_update=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: `alu_src_a`=01, `alu_src_b`=01, add (computes the branch target).
  - Next state by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other value → FETCH, with `illegal_op`=1.
- MEMADR:
  - Outputs: `alu_src_a`=10, `alu_src_b`=01, add.
  - Next state: MEMREAD if `op[5]`=0, else MEMWRITE.
- MEMREAD: `result_src`=00, `adr_src`=1 → MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1 → FETCH.
- MEMWRITE: `result_src`=00, `adr_src`=1, `mem_write`=1 → FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00, ALU op 10 → ALUWB.
- EXECI: `alu_src_a`=10, `alu_src_b`=01, ALU op 10 → ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1 → FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, add, `result_src`=00, pc_update=1 → ALUWB.
- BEQ: `alu_src_a`=10, `alu_src_b`=00, sub, `result_src`=00, branch=1 → FETCH.
- ALU decoder:
  - ALU op 00 → add; ALU op 01 → sub.
  - ALU op 10 decodes on `funct3`:
    - 000 → sub if `op[5]` & `funct7b5`, else add
    - 010 → slt
    - 110 → or
    - 111 → and
    - other values → add
- `imm_src` is a pure function of `op`, valid in every state:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - else → 00

## Timing
- Reset:
  - `reset`=1 at a rising edge forces `state`=FETCH; this is the only state initialisation.
  - While `reset`=1, `pc_write`, `ir_write`, `mem_write` and `reg_write` are forced to 0, regardless of state.
  - Other outputs follow FETCH decode.
- Reset mid-instruction: in any state, the next edge goes to FETCH. No write enable asserts in the reset cycle; the partial instruction is abandoned.
- Cycles per instruction, FETCH through the last state:
  - lw 5
  - sw 4
  - R-type 4
  - I-type ALU 4
  - jal 4
  - beq 3
  - illegal 2
- `pc_write` in BEQ follows `zero` combinationally in that same cycle.
- The `op` and `funct` inputs are sampled only from DECODE onward. The instruction register is written at the end of FETCH, so `op` is stable from DECODE until the next FETCH.
- `illegal_op` asserts only while `state`=DECODE and `reset`=0.

## Test plan
- Reset:
  - Stimulus: hold `reset` 2 cycles with `op`=0110011, then release.
  - Required: `state`=0; `ir_write`=`pc_write`=0 during reset; FETCH outputs with `ir_write`=`pc_write`=1 on the first cycle after release.
- lw:
  - Stimulus: `op`=0000011.
  - Required: `state` sequence 0,1,2,3,4,0; `reg_write`=1 only in state 4, with `result_src`=01; `imm_src`=00.
- sw:
  - Stimulus: `op`=0100011.
  - Required: sequence 0,1,2,5,0; `mem_write`=1 only in 5; `adr_src`=1; `imm_src`=01.
- beq:
  - Stimulus: `op`=1100011, once with `zero`=1 and once with `zero`=0.
  - Required: sequence 0,1,10,0; `alu_control`=001 in state 10; `pc_write` in state 10 is 1 and 0 respectively; `imm_src`=10.
- R-type and jal:
  - `op`=0110011, `funct3`=000, `funct7b5`=1 → `alu_control`=001 in EXECR.
  - `funct3`=111 → 010.
  - `op`=1101111 → sequence 0,1,9,7,0, with `pc_write`=1 in 9 and `imm_src`=11.
- Illegal opcode and reset mid-instruction:
  - `op`=1111111 → `illegal_op`=1 for exactly the DECODE cycle, then FETCH.
  - `reset` asserted in MEMREAD → next `state`=0, with `reg_write` never asserted.
